// File: rtl/axi_wm_pkg.sv
// Shared constants and FSM state type for the AXI3 burst write master.
package axi_wm_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DRAIN} wm_state_e;

endpackage

// File: rtl/axi_wm_cmd_check.sv
// Combinational legality check of a write command: beat size, address window, 4 KB page.
module axi_wm_cmd_check #(
    parameter int                   ADDR_BITS = 32,
    parameter int                   DATA_BITS = 32,
    parameter int                   LEN_BITS  = 4,
    parameter logic [ADDR_BITS-1:0] WIN_BASE  = 32'h0001_0000,
    parameter logic [ADDR_BITS-1:0] WIN_LIMIT = 32'h0001_FFFF
) (
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [LEN_BITS-1:0]  len,
    input  logic [2:0]           size,
    output logic                 legal
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_BITS / 8));

    // One extra bit so a burst running past the top of the address space cannot wrap into the window.
    logic [ADDR_BITS:0] nbytes;
    logic [ADDR_BITS:0] last;

    always_comb begin
        nbytes = (ADDR_BITS+1)'(len) + (ADDR_BITS+1)'(1);
        nbytes = nbytes << size;
        last   = {1'b0, addr} + nbytes - (ADDR_BITS+1)'(1);
        legal  = (size <= MAX_SIZE)
              && (addr >= WIN_BASE)
              && (last <= {1'b0, WIN_LIMIT})
              && (addr[ADDR_BITS-1:12] == last[ADDR_BITS-1:12]);
    end

endmodule

// File: rtl/axi_burst_write_master.sv
// AXI3 write master: one INCR burst per command, B response folded into a done pulse.
// Illegal commands drain their data beats locally and complete with SLVERR.
module axi_burst_write_master
    import axi_wm_pkg::*;
#(
    parameter int                   ID_BITS   = 4,
    parameter int                   ADDR_BITS = 32,
    parameter int                   DATA_BITS = 32,
    parameter int                   LEN_BITS  = 4,
    parameter logic [ADDR_BITS-1:0] WIN_BASE  = 32'h0001_0000,
    parameter logic [ADDR_BITS-1:0] WIN_LIMIT = 32'h0001_FFFF
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ID_BITS-1:0]     cmd_id,
    input  logic [ADDR_BITS-1:0]   cmd_addr,
    input  logic [LEN_BITS-1:0]    cmd_len,
    input  logic [2:0]             cmd_size,
    input  logic                   wd_valid,
    output logic                   wd_ready,
    input  logic [DATA_BITS-1:0]   wd_data,
    input  logic [DATA_BITS/8-1:0] wd_strb,
    output logic                   done_valid,
    output logic [ID_BITS-1:0]     done_id,
    output logic [1:0]             done_resp,
    output logic [ID_BITS-1:0]     AWID,
    output logic [ADDR_BITS-1:0]   AWADDR,
    output logic [LEN_BITS-1:0]    AWLEN,
    output logic [2:0]             AWSIZE,
    output logic [1:0]             AWBURST,
    output logic                   AWVALID,
    input  logic                   AWREADY,
    output logic [DATA_BITS-1:0]   WDATA,
    output logic [DATA_BITS/8-1:0] WSTRB,
    output logic                   WLAST,
    output logic                   WVALID,
    input  logic                   WREADY,
    input  logic [ID_BITS-1:0]     BID,
    input  logic [1:0]             BRESP,
    input  logic                   BVALID,
    output logic                   BREADY
);

    wm_state_e              state, state_n;
    logic [ID_BITS-1:0]     id_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [LEN_BITS-1:0]    len_q;
    logic [2:0]             size_q;
    logic [LEN_BITS-1:0]    beat_cnt;
    logic                   aw_done, w_done;
    logic                   legal;
    logic                   last_beat, aw_fire, w_fire, drain_fire;

    axi_wm_cmd_check #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .LEN_BITS  (LEN_BITS),
        .WIN_BASE  (WIN_BASE),
        .WIN_LIMIT (WIN_LIMIT)
    ) u_check (
        .addr  (cmd_addr),
        .len   (cmd_len),
        .size  (cmd_size),
        .legal (legal)
    );

    assign last_beat  = (beat_cnt == len_q);
    assign aw_fire    = (state == ADDR) && !aw_done && AWREADY;
    assign w_fire     = (state == ADDR) && !w_done && wd_valid && WREADY;
    assign drain_fire = (state == DRAIN) && wd_valid;

    assign AWID    = id_q;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = size_q;
    assign AWBURST = (state == ADDR) ? BURST_INCR : 2'b00;

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        WDATA     = '0;
        WSTRB     = '0;
        WLAST     = 1'b0;
        wd_ready  = 1'b0;
        BREADY    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !ARESET;
                if (cmd_valid && !ARESET)
                    state_n = legal ? ADDR : DRAIN;
            end
            ADDR: begin
                AWVALID = !aw_done;
                if (!w_done) begin
                    WVALID   = wd_valid;
                    wd_ready = WREADY;
                    WDATA    = wd_data;
                    WSTRB    = wd_strb;
                    WLAST    = last_beat;
                end
                if ((aw_done || aw_fire) && (w_done || (w_fire && last_beat)))
                    state_n = RESP;
            end
            RESP: begin
                BREADY = 1'b1;
                if (BVALID)
                    state_n = IDLE;
            end
            DRAIN: begin
                wd_ready = 1'b1;
                if (drain_fire && last_beat)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            beat_cnt   <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_resp  <= '0;
        end else begin
            state      <= state_n;
            done_valid <= 1'b0;
            if (state == IDLE && cmd_valid) begin
                id_q     <= cmd_id;
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                size_q   <= cmd_size;
                beat_cnt <= '0;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
            if (aw_fire)
                aw_done <= 1'b1;
            if (w_fire || drain_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (last_beat)
                    w_done <= 1'b1;
            end
            // A response carrying a foreign ID is not ours to trust.
            if (state == RESP && BVALID) begin
                done_valid <= 1'b1;
                done_id    <= id_q;
                done_resp  <= (BID == id_q) ? BRESP : RESP_SLVERR;
            end
            if (drain_fire && last_beat) begin
                done_valid <= 1'b1;
                done_id    <= id_q;
                done_resp  <= RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master with a queue-based expectation model.
module tb_axi_burst_write_master;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [3:0]  cmd_id = '0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic        wd_valid = 1'b0, wd_ready;
    logic [31:0] wd_data = '0;
    logic [3:0]  wd_strb = '0;
    logic        done_valid;
    logic [3:0]  done_id;
    logic [1:0]  done_resp;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY = 1'b1;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY = 1'b1;
    logic [3:0]  BID = '0;
    logic [1:0]  BRESP = '0;
    logic        BVALID = 1'b0, BREADY;

    axi_burst_write_master dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic [3:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size; } aw_t;
    typedef struct { logic [31:0] d; logic [3:0] s; logic l; } w_t;
    typedef struct { logic [3:0] id; logic [1:0] r; } d_t;
    aw_t exp_aw[$];
    w_t  exp_w[$];
    d_t  exp_done[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Legality straight from the rules: byte range of the burst in plain 64-bit arithmetic.
    function automatic bit model_legal(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size);
        longint unsigned nb, first, last;
        first = 64'(addr);
        nb    = (64'(len) + 1) << size;
        last  = first + nb - 1;
        return (size <= 3'd2) && (first >= 64'h1_0000) && (last <= 64'h1_FFFF)
            && ((first >> 12) == (last >> 12));
    endfunction

    function automatic logic [31:0] bdata(input logic [3:0] id, input int i);
        return 32'hA500_0000 | (32'(id) << 8) | 32'(i);
    endfunction

    function automatic logic [3:0] bstrb(input int i);
        return 4'hF >> (i % 4);
    endfunction

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (AWVALID) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    chk("awaddr", AWADDR, exp_aw[0].addr);
                    chk("awid", AWID, exp_aw[0].id);
                    chk("awlen", AWLEN, exp_aw[0].len);
                    chk("awsize", AWSIZE, exp_aw[0].size);
                    chk("awburst", AWBURST, 2'b01);
                    if (AWREADY) void'(exp_aw.pop_front());
                end
            end
            if (WVALID) begin
                if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    chk("wdata", WDATA, exp_w[0].d);
                    chk("wstrb", WSTRB, exp_w[0].s);
                    chk("wlast", WLAST, exp_w[0].l);
                    if (WREADY) void'(exp_w.pop_front());
                end
            end
            if (BREADY && exp_aw.size() != 0) chk("bready_before_aw", 1, 0);
            if (done_valid) begin
                if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    chk("done_id", done_id, exp_done[0].id);
                    chk("done_resp", done_resp, exp_done[0].r);
                    void'(exp_done.pop_front());
                end
            end
        end
    end

    task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size);
        bit ok = 0;
        cmd_valid = 1; cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size;
        for (int t = 0; t < 200; t++) begin
            @(negedge ACLK);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) timeout("cmd_ready");
        @(posedge ACLK); #1;
        cmd_valid = 0;
    endtask

    task automatic send_beats(input logic [3:0] id, input int n);
        for (int i = 0; i < n; i++) begin
            bit ok = 0;
            wd_valid = 1; wd_data = bdata(id, i); wd_strb = bstrb(i);
            for (int t = 0; t < 200; t++) begin
                @(negedge ACLK);
                if (wd_ready) begin ok = 1; break; end
            end
            if (!ok) begin timeout("wd_ready"); break; end
            @(posedge ACLK); #1;
        end
        wd_valid = 0;
    endtask

    task automatic aw_slave(input int delay);
        bit ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge ACLK);
            if (AWVALID) begin ok = 1; break; end
        end
        if (!ok) begin timeout("awvalid"); return; end
        repeat (delay) @(posedge ACLK);
        #1 AWREADY = 1;
        @(posedge ACLK); #1;
        AWREADY = 0;
    endtask

    task automatic b_slave(input int delay, input logic [3:0] bid, input logic [1:0] bresp);
        bit ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge ACLK);
            if (BREADY) begin ok = 1; break; end
        end
        if (!ok) begin timeout("bready"); return; end
        repeat (delay) @(posedge ACLK);
        #1 BVALID = 1; BID = bid; BRESP = bresp;
        @(posedge ACLK); #1;
        BVALID = 0;
    endtask

    task automatic run(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input int aw_delay, input int b_delay,
                       input logic [1:0] bresp, input bit bid_bad,
                       input logic [1:0] lit_resp, input bit lit_legal);
        bit legal;
        bit got;
        legal = model_legal(addr, len, size);
        chk("model_legal", 64'(legal), 64'(lit_legal));
        if (legal) begin
            exp_aw.push_back('{id, addr, len, size});
            for (int i = 0; i <= int'(len); i++)
                exp_w.push_back('{bdata(id, i), bstrb(i), (i == int'(len))});
        end
        exp_done.push_back('{id, (!legal || bid_bad) ? 2'b10 : bresp});
        @(posedge ACLK); #1;
        AWREADY = (aw_delay == 0);
        fork
            send_cmd(id, addr, len, size);
            send_beats(id, int'(len) + 1);
            begin if (legal && aw_delay > 0) aw_slave(aw_delay); end
            begin if (legal) b_slave(b_delay, bid_bad ? id ^ 4'h1 : id, bresp); end
        join
        got = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge ACLK); #1;
            if (exp_done.size() == 0) begin got = 1; break; end
        end
        if (!got) begin timeout("done_valid"); exp_done.delete(); end
        chk("done_resp_lit", done_resp, lit_resp);
        chk("done_id_lit", done_id, id);
        @(negedge ACLK);
        chk("done_one_cycle", done_valid, 0);
        chk("aw_all_seen", exp_aw.size(), 0);
        chk("w_all_seen", exp_w.size(), 0);
        exp_aw.delete(); exp_w.delete();
        AWREADY = 1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_awvalid"}, AWVALID, 0);
        chk({tag, "_wvalid"}, WVALID, 0);
        chk({tag, "_wd_ready"}, wd_ready, 0);
        chk({tag, "_bready"}, BREADY, 0);
        chk({tag, "_done_valid"}, done_valid, 0);
        chk({tag, "_done_id"}, done_id, 0);
        chk({tag, "_done_resp"}, done_resp, 0);
        chk({tag, "_aw_payload"}, {AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, 0);
        chk({tag, "_w_payload"}, {WDATA, WSTRB, WLAST}, 0);
    endtask

    initial begin
        repeat (2) @(negedge ACLK);
        chk_outputs_zero("reset");
        @(posedge ACLK); #1 ARESET = 0;

        // id, addr, len, size, aw_delay, b_delay, bresp, bid_bad, literal resp, literal legality
        run(4'd3,  32'h0001_0000, 4'd3, 3'd2, 0,  0, 2'b00, 0, 2'b00, 1);
        run(4'd4,  32'h0001_0040, 4'd1, 3'd2, 6,  0, 2'b00, 0, 2'b00, 1);
        run(4'd6,  32'h0002_0000, 4'd2, 3'd2, 0,  0, 2'b00, 0, 2'b10, 0);
        run(4'd7,  32'h0001_0FF8, 4'd3, 3'd2, 0,  0, 2'b00, 0, 2'b10, 0);
        run(4'd8,  32'h0001_0000, 4'd0, 3'd3, 0,  0, 2'b00, 0, 2'b10, 0);
        run(4'd9,  32'h0001_0100, 4'd2, 3'd2, 0, 10, 2'b11, 0, 2'b11, 1);
        run(4'd10, 32'h0001_0200, 4'd1, 3'd1, 0,  0, 2'b00, 1, 2'b10, 1);
        run(4'd11, 32'h0001_FFF0, 4'd3, 3'd2, 0,  0, 2'b01, 0, 2'b01, 1);
        run(4'd12, 32'h0001_FFF4, 4'd3, 3'd2, 0,  0, 2'b00, 0, 2'b10, 0);
        run(4'd13, 32'h0000_FFFC, 4'd0, 3'd2, 0,  0, 2'b00, 0, 2'b10, 0);
        run(4'd14, 32'h0001_0004, 4'd0, 3'd2, 0,  0, 2'b00, 0, 2'b00, 1);

        // Reset in the middle of a burst, with beat 3 already on the bus.
        @(posedge ACLK); #1;
        exp_aw.push_back('{4'd5, 32'h0001_0300, 4'd3, 3'd2});
        for (int i = 0; i < 4; i++) exp_w.push_back('{bdata(4'd5, i), bstrb(i), (i == 3)});
        fork
            send_cmd(4'd5, 32'h0001_0300, 4'd3, 3'd2);
            send_beats(4'd5, 2);
        join
        wd_valid = 1; wd_data = bdata(4'd5, 2); wd_strb = bstrb(2);
        #1 chk("pre_reset_wvalid", WVALID, 1);
        ARESET = 1;
        #1 chk_outputs_zero("midreset");
        wd_valid = 0;
        exp_aw.delete(); exp_w.delete(); exp_done.delete();
        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;
        repeat (5) @(negedge ACLK);
        run(4'd15, 32'h0001_0800, 4'd1, 3'd2, 0, 0, 2'b00, 0, 2'b00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
